// File: rtl/switch_out_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : switch_out_arbiter
//  Brief    : Round-robin arbiter and packet sequencer for one switch output
//             port. Grants one requester per packet, forwards its byte stream
//             (DA, SA, LEN, payload) with one cycle of latency, tracks the
//             packet length to release the grant, and inserts an
//             inter-packet gap.
//  Revision : 1.0  initial release
// ============================================================================
module switch_out_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int MAX_LEN    = 64,
  parameter int GAP_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PORTS-1:0]   req,
  input  logic [NUM_PORTS*8-1:0] req_data,
  input  logic [NUM_PORTS-1:0]   req_valid,
  output logic [NUM_PORTS-1:0]   grant,
  output logic [7:0]             data_out,
  output logic                   data_out_valid,
  output logic                   read_out,
  output logic                   pkt_done,
  output logic                   abort,
  output logic                   len_err
);

  localparam int                   IDX_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [IDX_W:0]       NUM_PORTS_W = (IDX_W+1)'(NUM_PORTS);
  localparam logic [IDX_W-1:0]     LAST_IDX    = IDX_W'(NUM_PORTS - 1);
  localparam logic [7:0]           MAX_LEN_B   = 8'(MAX_LEN);
  localparam logic [3:0]           GAP_LAST    = 4'(GAP_CYCLES - 1);
  localparam logic [NUM_PORTS-1:0] ONE_HOT0    = NUM_PORTS'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Registered state
  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] sel;
  logic [8:0]       cnt;
  logic [8:0]       total;
  logic [3:0]       gap_cnt;

  // Next-state values
  state_t           state_nxt;
  logic [IDX_W-1:0] ptr_nxt;
  logic [IDX_W-1:0] sel_nxt;
  logic [8:0]       cnt_nxt;
  logic [8:0]       total_nxt;
  logic [3:0]       gap_nxt;
  logic [NUM_PORTS-1:0] grant_nxt;
  logic [7:0]       dout_nxt;
  logic             dvalid_nxt;
  logic             read_out_nxt;
  logic             done_nxt;
  logic             abort_nxt;
  logic             lerr_nxt;

  // Arbitration and lane selection helpers
  logic [2*NUM_PORTS-1:0] req_rot;
  logic                   pick_found;
  logic [IDX_W:0]         pick_sum;
  logic [IDX_W-1:0]       pick_idx;
  logic [7:0]             lane_byte;
  logic                   lane_valid;
  logic                   lane_req;
  logic [7:0]             len_clip;
  logic [8:0]             total_dec;
  logic [8:0]             total_cur;
  logic                   is_last;
  logic [IDX_W-1:0]       next_port;

  // Round-robin search: rotate the request vector so ptr lands at bit 0,
  // then the lowest set bit is the winner; add ptr back modulo NUM_PORTS.
  always_comb begin
    req_rot    = {req, req} >> ptr;
    pick_found = 1'b0;
    pick_sum   = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        pick_found = 1'b1;
        pick_sum   = {1'b0, ptr} + (IDX_W+1)'(k);
      end
    end
    if (pick_sum >= NUM_PORTS_W) begin
      pick_idx = IDX_W'(pick_sum - NUM_PORTS_W);
    end else begin
      pick_idx = pick_sum[IDX_W-1:0];
    end
  end

  // Byte lane of the granted port; grant is one-hot so an OR-mux suffices.
  always_comb begin
    lane_byte = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        lane_byte = lane_byte | req_data[i*8 +: 8];
      end
    end
  end

  assign lane_valid = |(grant & req_valid);
  assign lane_req   = |(grant & req);

  // Length decode: the LEN byte sets the total byte count for this packet.
  // At cnt==2 the total is taken straight from the incoming byte so a
  // LEN=0 packet ends on that very byte.
  assign len_clip  = (lane_byte > MAX_LEN_B) ? MAX_LEN_B : lane_byte;
  assign total_dec = 9'd3 + {1'b0, len_clip};
  assign total_cur = (cnt == 9'd2) ? total_dec : total;
  assign is_last   = (cnt >= 9'd2) && (cnt == (total_cur - 9'd1));
  assign next_port = (sel == LAST_IDX) ? '0 : sel + IDX_W'(1);

  // Next-state and registered-output decode
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    sel_nxt    = sel;
    cnt_nxt    = cnt;
    total_nxt  = total;
    gap_nxt    = gap_cnt;
    grant_nxt  = grant;
    dout_nxt   = data_out;
    dvalid_nxt = 1'b0;
    done_nxt   = 1'b0;
    abort_nxt  = 1'b0;
    lerr_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (pick_found) begin
          sel_nxt   = pick_idx;
          grant_nxt = ONE_HOT0 << pick_idx;
          cnt_nxt   = '0;
          total_nxt = '0;
          state_nxt = XFER;
        end
      end

      XFER: begin
        if (!lane_req) begin
          // Requester withdrew before its last byte: drop the packet.
          abort_nxt = 1'b1;
          grant_nxt = '0;
          ptr_nxt   = next_port;
          gap_nxt   = '0;
          state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else if (lane_valid) begin
          dout_nxt   = lane_byte;
          dvalid_nxt = 1'b1;
          cnt_nxt    = cnt + 9'd1;
          if (cnt == 9'd2) begin
            total_nxt = total_dec;
            lerr_nxt  = (lane_byte > MAX_LEN_B);
          end
          if (is_last) begin
            done_nxt  = 1'b1;
            grant_nxt = '0;
            ptr_nxt   = next_port;
            gap_nxt   = '0;
            state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
          end
        end
      end

      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          gap_nxt = gap_cnt + 4'd1;
        end
      end

      default: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase

    read_out_nxt = (state_nxt != IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= '0;
      sel            <= '0;
      cnt            <= '0;
      total          <= '0;
      gap_cnt        <= '0;
      grant          <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      read_out       <= 1'b0;
      pkt_done       <= 1'b0;
      abort          <= 1'b0;
      len_err        <= 1'b0;
    end else begin
      state          <= state_nxt;
      ptr            <= ptr_nxt;
      sel            <= sel_nxt;
      cnt            <= cnt_nxt;
      total          <= total_nxt;
      gap_cnt        <= gap_nxt;
      grant          <= grant_nxt;
      data_out       <= dout_nxt;
      data_out_valid <= dvalid_nxt;
      read_out       <= read_out_nxt;
      pkt_done       <= done_nxt;
      abort          <= abort_nxt;
      len_err        <= lerr_nxt;
    end
  end

endmodule
`default_nettype wire
